// File: rtl/btn_debounce_edge_pkg.sv
// Shared state encoding for debounced-input blocks.
// Other blocks can import these states and helpers.
package btn_debounce_edge_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } db_state_e;

  // The accepted level is high in IDLE_HIGH and while a fall is still being qualified.
  function automatic logic db_level(input db_state_e st);
    return (st == IDLE_HIGH) || (st == WAIT_LOW);
  endfunction

  function automatic logic db_waiting(input db_state_e st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/btn_debounce_edge_sync_chain.sv
// Multi-flop synchroniser for one asynchronous input.
// The output is the last flop in the chain.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce_edge.sv
// Button conditioner: synchronise, debounce with a stability counter,
// then emit a registered level plus one-cycle rise/fall pulses.
module btn_debounce_edge
  import btn_debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic                 SINGLE   = (STABLE_CYCLES == 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_C = CNT_WIDTH'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic s;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (s)
  );

  db_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 busy_q, busy_d;

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW:
        if (s) begin
          if (SINGLE) state_d = IDLE_HIGH;
          else begin
            state_d = WAIT_HIGH;
            cnt_d   = ONE;
          end
        end
      WAIT_HIGH:
        if (!s) begin
          state_d = IDLE_LOW;  // bounce rejected
          cnt_d   = '0;
        end else if (cnt_inc == STABLE_C) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      IDLE_HIGH:
        if (!s) begin
          if (SINGLE) state_d = IDLE_LOW;
          else begin
            state_d = WAIT_LOW;
            cnt_d   = ONE;
          end
        end
      WAIT_LOW:
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_inc == STABLE_C) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
    // Outputs are derived from the next state so they change on the accepting edge.
    level_d = db_level(state_d);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
    busy_d  = db_waiting(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign btn_level  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule
